// File: rtl/fma_pkg.sv
// fma_pkg: shared definitions for the fma16 output stage.
//   NF/NE/NW      : fraction, exponent and result widths (half precision)
//   FLAG_*        : bit positions within the 4-bit {invalid, overflow, underflow, inexact} flags
//   fma_result_t  : 16-bit result word
//   fmaresult_state_t : occupancy state of the output buffer
//   fmaresult_entry_t : one buffered result + flags
package fma_pkg;
  localparam int NF = 10;
  localparam int NE = 5;
  localparam int NW = NE + NF + 1;

  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  typedef logic [NW-1:0] fma_result_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} fmaresult_state_t;

  typedef struct packed {
    fma_result_t res;
    logic [3:0]  flg;
  } fmaresult_entry_t;
endpackage

// File: rtl/fmaresult_flags.sv
// fmaflags: combinational result selection and IEEE flag generation.
//   r_sign/r_exp/r_fract : rounded value from the rounding stage
//   round_overflow       : overflow from the rounding stage
//   round_flags          : {sign, overflow, L, G, sticky}; only G and sticky used here
//   special_*            : special-case override (NaN/Inf/zero) and its invalid flag
//   result_o / flags_o   : assembled word and {invalid, overflow, underflow, inexact}
module fmaflags
  import fma_pkg::*;
(
  input  logic             r_sign,
  input  logic [NE-1:0]    r_exp,
  input  logic [NF-1:0]    r_fract,
  input  logic             round_overflow,
  input  logic [4:0]       round_flags,
  input  logic             special_valid,
  input  logic [NW-1:0]    special_result,
  input  logic             special_invalid,
  output fma_result_t      result_o,
  output logic [3:0]       flags_o
);
  logic inexact;
  logic unused_rflags;

  // sign, overflow copy and L are not needed for flag generation
  assign unused_rflags = ^round_flags[4:2];
  assign inexact       = round_overflow | round_flags[1] | round_flags[0];

  always_comb begin
    result_o = {r_sign, r_exp, r_fract};
    flags_o  = '0;
    if (special_valid) begin
      result_o               = special_result;
      flags_o[FLAG_INVALID]  = special_invalid;
    end else begin
      flags_o[FLAG_OVERFLOW]  = round_overflow;
      flags_o[FLAG_INEXACT]   = inexact;
      // tiny: exponent field zero after rounding and not an overflow
      flags_o[FLAG_UNDERFLOW] = inexact & (r_exp == '0) & ~round_overflow;
    end
  end
endmodule

// File: rtl/fmaresult.sv
// fmaresult: output stage of the fma16 datapath. Buffers the assembled result
// and flags behind a valid/ready handshake and keeps sticky accumulated flags.
//   clk, reset        : clock, async active-high reset
//   in_valid/in_ready : upstream handshake
//   r_*, round_*      : rounded value and rounding status
//   special_*         : special-case override
//   out_valid/out_ready, result, flags : downstream handshake and payload
//   acc_flags, acc_clear : sticky OR of emitted flags, synchronous clear
// Configuration macro: FMARESULT_SKID_EN selects a two-entry skid buffer with a
// registered in_ready; otherwise a single register with combinational in_ready.
module fmaresult
  import fma_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          r_sign,
  input  logic [NE-1:0] r_exp,
  input  logic [NF-1:0] r_fract,
  input  logic          round_overflow,
  input  logic [4:0]    round_flags,
  input  logic          special_valid,
  input  logic [NW-1:0] special_result,
  input  logic          special_invalid,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [NW-1:0] result,
  output logic [3:0]    flags,
  output logic [3:0]    acc_flags,
  input  logic          acc_clear
);
  fmaresult_entry_t  new_ent, main_q;
  fmaresult_state_t  state_q;
  logic [3:0]        acc_q, acc_d;
  logic              push, pop;

  fmaflags u_flags (
    .r_sign         (r_sign),
    .r_exp          (r_exp),
    .r_fract        (r_fract),
    .round_overflow (round_overflow),
    .round_flags    (round_flags),
    .special_valid  (special_valid),
    .special_result (special_result),
    .special_invalid(special_invalid),
    .result_o       (new_ent.res),
    .flags_o        (new_ent.flg)
  );

  assign out_valid = (state_q != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign result    = main_q.res;
  assign flags     = main_q.flg;

`ifdef FMARESULT_SKID_EN
  fmaresult_entry_t skid_q;
  logic             in_ready_q;

  assign in_ready = in_ready_q;

  // in_ready_q is computed alongside the state so it never depends on out_ready
  // combinationally; the skid entry absorbs the one extra op this allows.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      case (state_q)
        EMPTY: if (push) begin
          main_q  <= new_ent;
          state_q <= ONE;
        end
        ONE: begin
          if (push && !pop) begin
            skid_q     <= new_ent;
            state_q    <= TWO;
            in_ready_q <= 1'b0;
          end else if (pop && !push) begin
            state_q <= EMPTY;
          end else if (push && pop) begin
            main_q <= new_ent;
          end
        end
        TWO: if (pop) begin
          main_q     <= skid_q;
          state_q    <= ONE;
          in_ready_q <= 1'b1;
        end
        default: begin
          state_q    <= EMPTY;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end
`else
  assign in_ready = ~out_valid | out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
    end else begin
      if (push) begin
        main_q  <= new_ent;
        state_q <= ONE;
      end else if (pop) begin
        state_q <= EMPTY;
      end
    end
  end
`endif

  // a clear coinciding with an output transfer still keeps that output's flags
  always_comb begin
    acc_d = acc_q;
    if (pop)            acc_d = (acc_clear ? 4'b0000 : acc_q) | main_q.flg;
    else if (acc_clear) acc_d = 4'b0000;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign acc_flags = acc_q;
endmodule

// File: tb/tb_fmaresult.sv
module tb_fmaresult;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic        r_sign;
  logic [4:0]  r_exp;
  logic [9:0]  r_fract;
  logic        round_overflow;
  logic [4:0]  round_flags;
  logic        special_valid;
  logic [15:0] special_result;
  logic        special_invalid;
  logic        out_valid, out_ready;
  logic [15:0] result;
  logic [3:0]  flags, acc_flags;
  logic        acc_clear;

  int total = 0;
  int bad   = 0;
  logic [19:0] sb[$];

`ifdef FMARESULT_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  always #5 clk = ~clk;

  fmaresult dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .r_sign(r_sign), .r_exp(r_exp), .r_fract(r_fract),
    .round_overflow(round_overflow), .round_flags(round_flags),
    .special_valid(special_valid), .special_result(special_result),
    .special_invalid(special_invalid), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .flags(flags),
    .acc_flags(acc_flags), .acc_clear(acc_clear)
  );

  // reference model of the assembled word and flags
  function automatic logic [19:0] model();
    logic ix, uf;
    if (special_valid) return {special_result, special_invalid, 3'b000};
    ix = round_overflow | round_flags[1] | round_flags[0];
    uf = ix & (r_exp == 5'd0) & ~round_overflow;
    return {r_sign, r_exp, r_fract, 1'b0, round_overflow, uf, ix};
  endfunction

  // scoreboard: push on input transfer, pop and compare on output transfer
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        logic [19:0] e;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_order: unexpected output result=%h flags=%b", result, flags);
        end else begin
          e = sb.pop_front();
          if ({result, flags} !== e) begin
            bad++;
            $display("FAIL sb_order: got result=%h flags=%b want result=%h flags=%b",
                     result, flags, e[19:4], e[3:0]);
          end
        end
      end
      if (in_valid && in_ready) sb.push_back(model());
    end
  end

  task automatic set_norm(input logic s, input logic [4:0] e, input logic [9:0] f,
                          input logic ovf, input logic g, input logic st);
    special_valid = 0; special_result = 16'h0; special_invalid = 0;
    r_sign = s; r_exp = e; r_fract = f; round_overflow = ovf;
    round_flags = {s, ovf, 1'b0, g, st};
  endtask

  task automatic set_spec(input logic [15:0] w, input logic inv);
    set_norm(0, 5'd0, 10'd0, 0, 0, 0);
    special_valid = 1; special_result = w; special_invalid = inv;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    in_valid = 0; out_ready = 0; acc_clear = 0; set_norm(0, 0, 0, 0, 0, 0);
    reset = 1; tick(); tick(); reset = 0;
    @(negedge clk);
    total++;
    if ({out_valid, in_ready, result, flags, acc_flags} !== {1'b0, 1'b1, 16'h0, 4'h0, 4'h0}) begin
      bad++;
      $display("FAIL reset: ov=%b ir=%b res=%h fl=%b acc=%b want 0 1 0000 0000 0000",
               out_valid, in_ready, result, flags, acc_flags);
    end
    tick();
  endtask

  task automatic test_normal();
    set_norm(0, 5'h0F, 10'd0, 0, 0, 0); in_valid = 1; out_ready = 1;
    tick(); in_valid = 0;
    @(negedge clk); total++;
    if ({out_valid, result, flags} !== {1'b1, 16'h3C00, 4'b0000}) begin
      bad++;
      $display("FAIL normal: ov=%b res=%h fl=%b want 1 3c00 0000", out_valid, result, flags);
    end
    tick();
  endtask

  task automatic test_overflow();
    set_norm(0, 5'h1F, 10'd0, 1, 0, 0); in_valid = 1; out_ready = 1;
    tick(); in_valid = 0;
    @(negedge clk); total++;
    if ({out_valid, result, flags} !== {1'b1, 16'h7C00, 4'b0101}) begin
      bad++;
      $display("FAIL overflow: ov=%b res=%h fl=%b want 1 7c00 0101", out_valid, result, flags);
    end
    tick();
  endtask

  task automatic test_tiny();
    set_norm(0, 5'h00, 10'h001, 0, 0, 1); in_valid = 1; out_ready = 1;
    tick(); in_valid = 0;
    @(negedge clk); total++;
    if ({out_valid, result, flags} !== {1'b1, 16'h0001, 4'b0011}) begin
      bad++;
      $display("FAIL tiny: ov=%b res=%h fl=%b want 1 0001 0011", out_valid, result, flags);
    end
    tick();
  endtask

  task automatic test_special();
    out_ready = 0; acc_clear = 1; tick(); acc_clear = 0;
    @(negedge clk); total++;
    if (acc_flags !== 4'b0000) begin
      bad++; $display("FAIL acc_clear_idle: acc=%b want 0000", acc_flags);
    end
    tick();
    set_spec(16'h7E00, 1); in_valid = 1; out_ready = 1;
    tick(); in_valid = 0;
    @(negedge clk); total++;
    if ({out_valid, result, flags} !== {1'b1, 16'h7E00, 4'b1000}) begin
      bad++;
      $display("FAIL special: ov=%b res=%h fl=%b want 1 7e00 1000", out_valid, result, flags);
    end
    tick();
    @(negedge clk); total++;
    if (acc_flags !== 4'b1000) begin
      bad++; $display("FAIL special_acc: acc=%b want 1000", acc_flags);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int k = 0;
    int n;
    out_ready = 0;
    for (int c = 0; c < 3; c++) begin
      case (k)
        0: set_norm(0, 5'h0F, 10'h000, 0, 0, 0);
        1: set_norm(1, 5'h1F, 10'h000, 1, 0, 0);
        default: set_norm(0, 5'h00, 10'h001, 0, 0, 1);
      endcase
      in_valid = 1;
      @(negedge clk);
      if (in_ready) k++;
      tick();
    end
    total++;
    if (k !== DEPTH) begin
      bad++; $display("FAIL bp_accepted: got %0d want %0d", k, DEPTH);
    end
    @(negedge clk); total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      bad++; $display("FAIL bp_in_ready: ir=%b ov=%b want 0 1", in_ready, out_valid);
    end
    tick();
    out_ready = 1;
    n = 0;
    while (k < 3 && n < 20) begin
      case (k)
        1: set_norm(1, 5'h1F, 10'h000, 1, 0, 0);
        default: set_norm(0, 5'h00, 10'h001, 0, 0, 1);
      endcase
      in_valid = 1;
      @(negedge clk);
      if (in_ready) k++;
      tick(); n++;
    end
    in_valid = 0;
    n = 0;
    while (out_valid && n < 20) begin tick(); n++; end
    @(negedge clk); total++;
    if (k !== 3 || out_valid !== 1'b0 || sb.size() != 0) begin
      bad++;
      $display("FAIL bp_drain: accepted=%0d ov=%b pending=%0d want 3 0 0", k, out_valid, sb.size());
    end
    tick();
  endtask

  task automatic test_acc_clear();
    out_ready = 0;
    set_norm(0, 5'h01, 10'h000, 0, 1, 0); in_valid = 1;
    tick(); in_valid = 0;
    @(negedge clk); total++;
    if (acc_flags === 4'b0000 || out_valid !== 1'b1) begin
      bad++; $display("FAIL accclr_setup: acc=%b ov=%b want nonzero 1", acc_flags, out_valid);
    end
    tick();
    out_ready = 1; acc_clear = 1;
    tick(); acc_clear = 0;
    @(negedge clk); total++;
    if (acc_flags !== 4'b0001) begin
      bad++; $display("FAIL accclr_handshake: acc=%b want 0001", acc_flags);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic acc;
    int   outs = 0;
    out_ready = 1; in_valid = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      if (out_valid && out_ready) outs++;
      tick();
      if (acc || !in_valid) begin
        in_valid = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 4) == 0) set_spec(16'($urandom), 1'($urandom));
        else set_norm(1'($urandom), 5'($urandom), 10'($urandom),
                      1'($urandom_range(0, 5) == 0), 1'($urandom), 1'($urandom));
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid = 0; out_ready = 1;
    for (int n = 0; n < 20 && out_valid; n++) tick();
    @(negedge clk); total++;
    if (out_valid !== 1'b0 || sb.size() != 0 || outs == 0) begin
      bad++;
      $display("FAIL b2b_drain: ov=%b pending=%0d outs=%0d want 0 0 >0", out_valid, sb.size(), outs);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 0;
    set_norm(0, 5'h0A, 10'h155, 0, 1, 1); in_valid = 1; tick();
    set_norm(1, 5'h03, 10'h2AA, 0, 0, 1); tick();
    in_valid = 0;
    #1 reset = 1;
    #1; total++;
    if ({out_valid, in_ready, result, flags, acc_flags} !== {1'b0, 1'b1, 16'h0, 4'h0, 4'h0}) begin
      bad++;
      $display("FAIL reset_mid: ov=%b ir=%b res=%h fl=%b acc=%b want 0 1 0000 0000 0000",
               out_valid, in_ready, result, flags, acc_flags);
    end
    sb.delete();
    tick(); reset = 0; tick();
  endtask

  initial begin
    test_reset();
    test_normal();
    test_overflow();
    test_tiny();
    test_special();
    test_backpressure();
    test_acc_clear();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
